// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing constants shared by the sync generator,
// the pixel generator and the game logic, plus a small window-decode helper.
// Ports: none (package).
package vga_timing_pkg;

  localparam int VGA_COUNT_W   = 10;

  localparam int VGA_H_DISPLAY = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_H_TOTAL   = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int VGA_H_SYNC_START = VGA_H_DISPLAY + VGA_H_FRONT;
  localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC - 1;

  localparam int VGA_V_DISPLAY = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;
  localparam int VGA_V_TOTAL   = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;
  localparam int VGA_V_SYNC_START = VGA_V_DISPLAY + VGA_V_FRONT;
  localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC - 1;

  localparam int VGA_TICK_DIV  = 4;

  // Inclusive unsigned window test used for the sync pulse decode.
  function automatic logic in_window(input logic [VGA_COUNT_W-1:0] v,
                                     input logic [VGA_COUNT_W-1:0] lo,
                                     input logic [VGA_COUNT_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// pixel_tick_gen: divides the system clock down to a one-clk pixel strobe.
// Ports:
//   clk        system clock
//   reset      synchronous, active-low reset (divider cleared to 0)
//   pixel_tick high for one clk every TICK_DIV clks (when divider = TICK_DIV-1)
module pixel_tick_gen
  import vga_timing_pkg::*;
#(
  parameter int TICK_DIV = VGA_TICK_DIV
)(
  input  logic clk,
  input  logic reset,
  output logic pixel_tick
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] divider;

  always_ff @(posedge clk) begin
    if (!reset) begin
      divider <= '0;
    end else if (divider == DIV_LAST) begin
      divider <= '0;
    end else begin
      divider <= divider + DIV_W'(1);
    end
  end

  // Decoded from the divider register only, so the strobe is low while in reset.
  assign pixel_tick = (divider == DIV_LAST);

endmodule

// File: rtl/vga_sync.sv
// vga_sync: VGA raster counters and sync generation.
// Ports:
//   clk         system clock
//   reset       synchronous, active-low reset
//   hsync       horizontal sync, active-low, registered
//   vsync       vertical sync, active-low, registered
//   video_on    current pixel lies in the visible area
//   pixel_tick  one-clk strobe per pixel period
//   pixel_x     horizontal count 0..H_TOTAL-1
//   pixel_y     vertical count 0..V_TOTAL-1
//   frame_tick  one-clk strobe on the last pixel of a frame
module vga_sync
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY = VGA_H_DISPLAY,
  parameter int H_FRONT   = VGA_H_FRONT,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BACK    = VGA_H_BACK,
  parameter int V_DISPLAY = VGA_V_DISPLAY,
  parameter int V_FRONT   = VGA_V_FRONT,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BACK    = VGA_V_BACK,
  parameter int TICK_DIV  = VGA_TICK_DIV
)(
  input  logic                   clk,
  input  logic                   reset,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   video_on,
  output logic                   pixel_tick,
  output logic [VGA_COUNT_W-1:0] pixel_x,
  output logic [VGA_COUNT_W-1:0] pixel_y,
  output logic                   frame_tick
);

  localparam int CW = VGA_COUNT_W;

  localparam logic [CW-1:0] H_LAST   = CW'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_DISPLAY);
  localparam logic [CW-1:0] V_VIS    = CW'(V_DISPLAY);
  localparam logic [CW-1:0] HS_FIRST = CW'(H_DISPLAY + H_FRONT);
  localparam logic [CW-1:0] HS_LAST  = CW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST = CW'(V_DISPLAY + V_FRONT);
  localparam logic [CW-1:0] VS_LAST  = CW'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic          tick;
  logic          line_end;
  logic [CW-1:0] x_next;
  logic [CW-1:0] y_next;

  pixel_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_pixel_tick_gen (
    .clk        (clk),
    .reset      (reset),
    .pixel_tick (tick)
  );

  assign line_end = tick && (pixel_x == H_LAST);

  always_comb begin
    x_next = pixel_x;
    y_next = pixel_y;
    if (tick) begin
      if (pixel_x == H_LAST) begin
        x_next = '0;
        y_next = (pixel_y == V_LAST) ? '0 : pixel_y + CW'(1);
      end else begin
        x_next = pixel_x + CW'(1);
      end
    end
  end

  // Syncs are decoded from the next-state counts so they toggle on the same
  // edge as pixel_x/pixel_y instead of lagging one pixel behind.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pixel_x <= '0;
      pixel_y <= '0;
      hsync   <= 1'b1;
      vsync   <= 1'b1;
    end else begin
      pixel_x <= x_next;
      pixel_y <= y_next;
      hsync   <= ~in_window(x_next, HS_FIRST, HS_LAST);
      vsync   <= ~in_window(y_next, VS_FIRST, VS_LAST);
    end
  end

  assign pixel_tick = tick;
  assign frame_tick = line_end && (pixel_y == V_LAST);
  assign video_on   = (pixel_x < H_VIS) && (pixel_y < V_VIS);

endmodule

// File: tb/tb_vga_sync.sv
module tb_vga_sync;

  // Reduced raster for the randomized instance so many frames fit in the run.
  localparam int SHD = 8, SHF = 2, SHS = 3, SHB = 2;
  localparam int SVD = 5, SVF = 1, SVS = 2, SVB = 1;
  localparam int STD = 4;
  localparam int SHT = SHD + SHF + SHS + SHB;  // 15
  localparam int SVT = SVD + SVF + SVS + SVB;  // 9

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_s = 1'b0;
  logic       hs_s, vs_s, von_s, tick_s, ft_s;
  logic [9:0] x_s, y_s;

  logic       reset_f = 1'b0;
  logic       hs_f, vs_f, von_f, tick_f, ft_f;
  logic [9:0] x_f, y_f;

  vga_sync #(
    .H_DISPLAY(SHD), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_DISPLAY(SVD), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
    .TICK_DIV(STD)
  ) u_small (
    .clk(clk), .reset(reset_s), .hsync(hs_s), .vsync(vs_s), .video_on(von_s),
    .pixel_tick(tick_s), .pixel_x(x_s), .pixel_y(y_s), .frame_tick(ft_s)
  );

  vga_sync u_full (
    .clk(clk), .reset(reset_f), .hsync(hs_f), .vsync(vs_f), .video_on(von_f),
    .pixel_tick(tick_f), .pixel_x(x_f), .pixel_y(y_f), .frame_tick(ft_f)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got %0d, expected %0d (time %0t)", name, act, exp, $time);
    end
  endtask

  // Model: the whole raster position is a pure function of clocks elapsed
  // since the last reset edge.
  int t_mdl = 0;
  bit mdl_valid = 1'b0;

  always @(posedge clk) begin
    if (!reset_s) begin
      t_mdl     <= 0;
      mdl_valid <= 1'b1;
    end else begin
      t_mdl <= t_mdl + 1;
    end
  end

  bit prev_tick = 1'b0;

  always @(negedge clk) begin
    if (mdl_valid) begin
      int pix, ex, ey, etick, ehs, evs, evon, eft;
      pix   = t_mdl / STD;
      ex    = pix % SHT;
      ey    = (pix / SHT) % SVT;
      etick = ((t_mdl % STD) == STD - 1) ? 1 : 0;
      ehs   = (ex >= SHD + SHF && ex < SHD + SHF + SHS) ? 0 : 1;
      evs   = (ey >= SVD + SVF && ey < SVD + SVF + SVS) ? 0 : 1;
      evon  = (ex < SHD && ey < SVD) ? 1 : 0;
      eft   = (etick == 1 && ex == SHT - 1 && ey == SVT - 1) ? 1 : 0;
      chk("pixel_x",    int'(x_s),    ex);
      chk("pixel_y",    int'(y_s),    ey);
      chk("pixel_tick", int'(tick_s), etick);
      chk("hsync",      int'(hs_s),   ehs);
      chk("vsync",      int'(vs_s),   evs);
      chk("video_on",   int'(von_s),  evon);
      chk("frame_tick", int'(ft_s),   eft);
      chk("tick_back_to_back", int'(prev_tick && tick_s), 0);
      prev_tick = tick_s;
    end
  end

  task automatic goto_t(input int target);
    repeat (target - t_mdl) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int hs_cnt, hs_x, vs_cnt, hold;

    // Full-size raster: first ticks and one complete line.
    reset_f = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("full_rst_hsync", int'(hs_f), 1);
    chk("full_rst_video_on", int'(von_f), 1);
    reset_f = 1'b1;
    hs_cnt = 0; hs_x = -1; vs_cnt = 0;
    for (int t = 0; t <= 3200; t++) begin
      if (t < 8) begin
        chk("full_tick_early", int'(tick_f), (t % 4 == 3) ? 1 : 0);
        chk("full_x_early", int'(x_f), t / 4);
      end
      if (!hs_f) begin
        if (hs_cnt == 0) hs_x = int'(x_f);
        hs_cnt++;
      end
      if (!vs_f) vs_cnt++;
      if (t == 3199) begin
        chk("full_x_line_end", int'(x_f), 799);
        chk("full_y_line_end", int'(y_f), 0);
        chk("full_tick_line_end", int'(tick_f), 1);
      end
      if (t < 3200) begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    chk("full_x_wrap", int'(x_f), 0);
    chk("full_y_inc", int'(y_f), 1);
    chk("full_hs_low_clks", hs_cnt, 384);
    chk("full_hs_first_x", hs_x, 656);
    chk("full_vs_low_clks", vs_cnt, 0);

    // Reduced raster: literal checkpoints from a clean reset.
    @(negedge clk);
    chk("s_rst_x", int'(x_s), 0);
    chk("s_rst_hsync", int'(hs_s), 1);
    chk("s_rst_video_on", int'(von_s), 1);
    chk("s_rst_tick", int'(tick_s), 0);
    reset_s = 1'b1;
    goto_t(3);   chk("s_t3_tick", int'(tick_s), 1); chk("s_t3_x", int'(x_s), 0);
    goto_t(4);   chk("s_t4_tick", int'(tick_s), 0); chk("s_t4_x", int'(x_s), 1);
    goto_t(32);  chk("s_x8_video_on", int'(von_s), 0);
    goto_t(39);  chk("s_x9_hsync", int'(hs_s), 1);
    goto_t(40);  chk("s_x10_hsync", int'(hs_s), 0);
    goto_t(51);  chk("s_x12_hsync", int'(hs_s), 0);
    goto_t(52);  chk("s_x13_hsync", int'(hs_s), 1);
    goto_t(60);  chk("s_wrap_x", int'(x_s), 0); chk("s_wrap_y", int'(y_s), 1);
    goto_t(300); chk("s_y5_video_on", int'(von_s), 0);
    goto_t(360); chk("s_y6_vsync", int'(vs_s), 0);
    goto_t(469); chk("s_pre_rst_vsync", int'(vs_s), 0); chk("s_pre_rst_x", int'(x_s), 12);

    // Reset in the middle of the vsync pulse.
    reset_s = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("s_midrst_x", int'(x_s), 0);
    chk("s_midrst_y", int'(y_s), 0);
    chk("s_midrst_hsync", int'(hs_s), 1);
    chk("s_midrst_vsync", int'(vs_s), 1);
    chk("s_midrst_tick", int'(tick_s), 0);
    reset_s = 1'b1;

    goto_t(539); chk("s_frame_tick", int'(ft_s), 1); chk("s_last_y", int'(y_s), 8);
    goto_t(540); chk("s_frame_wrap_x", int'(x_s), 0); chk("s_frame_wrap_y", int'(y_s), 0);

    // Randomized reset pulses over many reduced frames.
    hold = 0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (hold > 0) begin
        hold--;
        reset_s = 1'b0;
      end else if ($urandom_range(0, 599) == 0) begin
        reset_s = 1'b0;
        hold = $urandom_range(0, 2);
      end else begin
        reset_s = 1'b1;
      end
    end
    reset_s = 1'b1;
    repeat (1200) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vga_sync.md
VGA_SYNC -- requirements
Module: vga_sync

Interface
REQ-001 Parameter H_DISPLAY, 640, visible pixels per line.
REQ-002 Parameter H_FRONT, 16, horizontal front-porch pixels.
REQ-003 Parameter H_SYNC, 96, horizontal sync-pulse pixels.
REQ-004 Parameter H_BACK, 48, horizontal back-porch pixels (line total 800).
REQ-005 Parameter V_DISPLAY, 480, visible lines per frame.
REQ-006 Parameter V_FRONT, 10, vertical front-porch lines.
REQ-007 Parameter V_SYNC, 2, vertical sync-pulse lines.
REQ-008 Parameter V_BACK, 33, vertical back-porch lines (frame total 525).
REQ-009 Parameter TICK_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz).
REQ-010 clk  in  1  system clock; all state changes on its rising edge.
REQ-011 reset  in  1  synchronous, active-low reset.
REQ-012 hsync  out  1  horizontal sync, active-low, registered.
REQ-013 vsync  out  1  vertical sync, active-low, registered.
REQ-014 video_on  out  1  high while the current pixel is inside the 640x480 visible area.
REQ-015 pixel_tick  out  1  one-clk strobe marking each pixel period.
REQ-016 pixel_x  out  10  current horizontal count, 0..799.
REQ-017 pixel_y  out  10  current vertical count, 0..524.
REQ-018 frame_tick  out  1  one-clk strobe on the last pixel of a frame.

Function
REQ-019 Divider counts 0..TICK_DIV-1, +1 every clk, wraps to 0; pixel_tick = 1 exactly when divider = TICK_DIV-1.
REQ-020 pixel_x advances only on clks where pixel_tick = 1; pixel_x = 799 with pixel_tick -> pixel_x = 0 next clk.
REQ-021 pixel_y advances only when pixel_tick = 1 and pixel_x = 799; pixel_y = 524 at that point -> pixel_y = 0.
REQ-022 Both counters hold their value on clks with pixel_tick = 0.
REQ-023 hsync = 0 for pixel_x in [656, 751] (H_DISPLAY+H_FRONT .. +H_SYNC-1), else 1.
REQ-024 vsync = 0 for pixel_y in [490, 491], else 1.
REQ-025 hsync/vsync are registered from next-state counter values so they change on the same clk edge as pixel_x/pixel_y (no one-pixel skew).
REQ-026 video_on = (pixel_x < 640) and (pixel_y < 480), aligned with pixel_x/pixel_y.
REQ-027 frame_tick = 1 only on the clk where pixel_tick = 1, pixel_x = 799, pixel_y = 524.
REQ-028 Counter widths are 10 bits; no count ever exceeds total-1; all comparisons unsigned.
REQ-029 Downstream pixel generator samples pixel_x/pixel_y/video_on qualified by pixel_tick; outputs stay stable between ticks.

Reset
REQ-030 reset = 0 at a rising edge forces: divider 0, pixel_x 0, pixel_y 0, hsync 1, vsync 1, pixel_tick 0, frame_tick 0.
REQ-031 video_on evaluates to 1 during and after reset (counters at 0,0).
REQ-032 Reset asserted mid-frame overrides all counting the same edge; no partial sync pulse continues.
REQ-033 First pixel_tick after reset release occurs TICK_DIV clks after the first edge with reset = 1 (divider reaches TICK_DIV-1).

Structure
REQ-034 Timing constants (display/porch/sync per axis, totals, sync start/end) live in shared package vga_timing_pkg, also used by the pixel generator and game logic.
REQ-035 Divider is sub-module pixel_tick_gen (params TICK_DIV; ports clk, reset, pixel_tick); counters and sync decode stay in vga_sync.
REQ-036 No combinational path from any input to any output except through registers.

Verification
REQ-037 Release reset, run 8 clks -> pixel_tick high on clks 4 and 8 only; pixel_x = 0 then 1 then 2.
REQ-038 Run one line (3200 clks) -> hsync low for exactly 96 ticks (384 clks), starting when pixel_x becomes 656; pixel_y increments 0 -> 1 as pixel_x wraps 799 -> 0.
REQ-039 Run one frame (1,680,000 clks) -> vsync low for exactly 2 lines (1600 ticks), pixel_y 490..491; exactly one frame_tick, at (799,524); counters return to (0,0).
REQ-040 Sweep full frame -> video_on high for exactly 307,200 ticks; low at pixel_x = 640 and at pixel_y = 480.
REQ-041 Assert reset at pixel_x = 700, pixel_y = 491 (vsync low) -> next edge pixel_x = 0, pixel_y = 0, hsync = 1, vsync = 1, pixel_tick = 0.
REQ-042 Check pixel_x never exceeds 799, pixel_y never exceeds 524, pixel_tick never high two consecutive clks (assertions, full frame).
